sa_job_sched: RTL and testbench

Job scheduler for the X×N · N×Y systolic matrix-multiply array. It arbitrates round-robin between REQ requesters, for example the EKF predict and update stages. For the granted requester it then sequences one complete multiply:
- streams operand-buffer read addresses and the Xin_val/Yin_val strobes into the array configuration block;
- waits for the array's cal_done;
- writes X·Y results back at the requester's result base address;
- pulses that requester's done.

It sits between the EKF control layer and the array configuration block.

---
 rtl/sa_job_sched.sv | 208 ++++++++++++++++++++
 tb/tb_sa_job_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_job_sched.sv
// sa_job_sched: round-robin job scheduler for the XxN * NxY systolic multiply array.
// Streams operand reads, collects results, and signals done or timeout per job.
`default_nettype none

module sa_job_sched #(
  parameter int X          = 3,
  parameter int N          = 3,
  parameter int Y          = 3,
  parameter int REQ        = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic [REQ-1:0]            req,
  input  logic [REQ*ADDR_WIDTH-1:0] a_base,
  input  logic [REQ*ADDR_WIDTH-1:0] b_base,
  input  logic [REQ*ADDR_WIDTH-1:0] c_base,
  input  logic                      cal_done,
  input  logic                      res_val,
  output logic [REQ-1:0]            grant,
  output logic [REQ-1:0]            done,
  output logic                      err,
  output logic                      Xin_val,
  output logic                      Yin_val,
  output logic                      a_rd_en,
  output logic [ADDR_WIDTH-1:0]     a_rd_addr,
  output logic                      b_rd_en,
  output logic [ADDR_WIDTH-1:0]     b_rd_addr,
  output logic                      c_wr_en,
  output logic [ADDR_WIDTH-1:0]     c_wr_addr
);

  localparam int XN   = X * N;
  localparam int NY   = N * Y;
  localparam int XY   = X * Y;
  localparam int M1   = (XN > NY) ? XN : NY;
  localparam int M2   = (M1 > XY) ? M1 : XY;
  localparam int MAXV = (M2 > TIMEOUT) ? M2 : TIMEOUT;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int PW   = $clog2(REQ);

  localparam logic [CW-1:0] XN_C = CW'(XN);
  localparam logic [CW-1:0] NY_C = CW'(NY);
  localparam logic [CW-1:0] XY_C = CW'(XY);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t                state, state_nx;
  logic [PW-1:0]         ptr, ptr_nx, pick, idx;
  logic                  found, accept, seen;
  logic [ADDR_WIDTH-1:0] a_lat, b_lat, c_lat, a_lat_nx, b_lat_nx, c_lat_nx;
  logic [CW-1:0]         ka, kb, kc, wd, ka_nx, kb_nx, kc_nx, wd_nx;
  logic                  cal_seen, cal_seen_nx;
  logic [REQ-1:0]        grant_nx, done_nx;
  logic                  err_nx, xin_nx, yin_nx, c_wr_en_nx;
  logic [ADDR_WIDTH-1:0] a_rd_addr_nx, b_rd_addr_nx, c_wr_addr_nx;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      ptr       <= PW'(REQ - 1);
      a_lat     <= '0;
      b_lat     <= '0;
      c_lat     <= '0;
      ka        <= '0;
      kb        <= '0;
      kc        <= '0;
      wd        <= '0;
      cal_seen  <= 1'b0;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      Xin_val   <= 1'b0;
      Yin_val   <= 1'b0;
      a_rd_en   <= 1'b0;
      b_rd_en   <= 1'b0;
      c_wr_en   <= 1'b0;
      a_rd_addr <= '0;
      b_rd_addr <= '0;
      c_wr_addr <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      a_lat     <= a_lat_nx;
      b_lat     <= b_lat_nx;
      c_lat     <= c_lat_nx;
      ka        <= ka_nx;
      kb        <= kb_nx;
      kc        <= kc_nx;
      wd        <= wd_nx;
      cal_seen  <= cal_seen_nx;
      grant     <= grant_nx;
      done      <= done_nx;
      err       <= err_nx;
      Xin_val   <= xin_nx;
      Yin_val   <= yin_nx;
      a_rd_en   <= xin_nx;
      b_rd_en   <= yin_nx;
      c_wr_en   <= c_wr_en_nx;
      a_rd_addr <= a_rd_addr_nx;
      b_rd_addr <= b_rd_addr_nx;
      c_wr_addr <= c_wr_addr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    a_lat_nx     = a_lat;
    b_lat_nx     = b_lat;
    c_lat_nx     = c_lat;
    ka_nx        = ka;
    kb_nx        = kb;
    kc_nx        = kc;
    wd_nx        = wd;
    cal_seen_nx  = cal_seen;
    grant_nx     = grant;
    done_nx      = '0;
    err_nx       = 1'b0;
    xin_nx       = 1'b0;
    yin_nx       = 1'b0;
    c_wr_en_nx   = 1'b0;
    a_rd_addr_nx = a_rd_addr;
    b_rd_addr_nx = b_rd_addr;
    c_wr_addr_nx = c_wr_addr;
    found        = 1'b0;
    pick         = '0;
    idx          = '0;

    // Round-robin search starting just after the last winner
    for (int i = 1; i <= REQ; i++) begin
      idx = PW'((int'(ptr) + i) % REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    accept = res_val && (kc < XY_C) && ((state == LOAD) || (state == RUN));
    seen   = cal_seen | cal_done;
    if (accept) begin
      c_wr_en_nx   = 1'b1;
      c_wr_addr_nx = c_lat + ADDR_WIDTH'(kc);
      kc_nx        = kc + 1'b1;
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_nx     = LOAD;
          ptr_nx       = pick;
          grant_nx     = REQ'(1) << pick;
          a_lat_nx     = a_base[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          b_lat_nx     = b_base[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          c_lat_nx     = c_base[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          a_rd_addr_nx = a_base[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          b_rd_addr_nx = b_base[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          xin_nx       = 1'b1;
          yin_nx       = 1'b1;
          ka_nx        = CW'(1);
          kb_nx        = CW'(1);
          kc_nx        = '0;
          wd_nx        = '0;
          cal_seen_nx  = 1'b0;
        end
      end
      LOAD: begin
        cal_seen_nx = seen;
        // ka/kb count reads already issued; the first one went out at grant
        if (ka < XN_C) begin
          xin_nx       = 1'b1;
          a_rd_addr_nx = a_lat + ADDR_WIDTH'(ka);
          ka_nx        = ka + 1'b1;
        end
        if (kb < NY_C) begin
          yin_nx       = 1'b1;
          b_rd_addr_nx = b_lat + ADDR_WIDTH'(kb);
          kb_nx        = kb + 1'b1;
        end
        if ((ka >= XN_C) && (kb >= NY_C)) state_nx = RUN;
      end
      RUN: begin
        cal_seen_nx = seen;
        if (seen && (kc_nx == XY_C)) begin
          state_nx = FIN;
          done_nx  = grant;
        end else begin
          wd_nx = wd + 1'b1;
          if ((wd + 1'b1) == TO_C) begin
            err_nx   = 1'b1;
            grant_nx = '0;
            state_nx = IDLE;
          end
        end
      end
      FIN: begin
        grant_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sa_job_sched.sv
// tb_sa_job_sched: directed stimulus against a job-level reference model of sa_job_sched,
// with instance 0 at default geometry and instance 1 at X=2, N=4, Y=3.
`default_nettype none

module tb_sa_job_sched;

  localparam int X0 = 3, N0 = 3, Y0 = 3;
  localparam int X1 = 2, N1 = 4, Y1 = 3;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req0, req1;
  logic [15:0] a_base, b_base, c_base;
  logic        cal_done, res_val;
  logic        chk_en;

  logic [1:0]  grant_o [2];
  logic [1:0]  done_o  [2];
  logic        err_o   [2];
  logic        xin_o   [2];
  logic        yin_o   [2];
  logic        arde_o  [2];
  logic        brde_o  [2];
  logic        cwe_o   [2];
  logic [7:0]  aaddr_o [2];
  logic [7:0]  baddr_o [2];
  logic [7:0]  caddr_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_job_sched #(.X(X0), .N(N0), .Y(Y0), .REQ(2), .ADDR_WIDTH(8), .TIMEOUT(TO)) dut0 (
    .clk(clk), .sys_rst_n(rst_n), .req(req0),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .cal_done(cal_done), .res_val(res_val),
    .grant(grant_o[0]), .done(done_o[0]), .err(err_o[0]),
    .Xin_val(xin_o[0]), .Yin_val(yin_o[0]),
    .a_rd_en(arde_o[0]), .a_rd_addr(aaddr_o[0]),
    .b_rd_en(brde_o[0]), .b_rd_addr(baddr_o[0]),
    .c_wr_en(cwe_o[0]), .c_wr_addr(caddr_o[0])
  );

  sa_job_sched #(.X(X1), .N(N1), .Y(Y1), .REQ(2), .ADDR_WIDTH(8), .TIMEOUT(TO)) dut1 (
    .clk(clk), .sys_rst_n(rst_n), .req(req1),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .cal_done(cal_done), .res_val(res_val),
    .grant(grant_o[1]), .done(done_o[1]), .err(err_o[1]),
    .Xin_val(xin_o[1]), .Yin_val(yin_o[1]),
    .a_rd_en(arde_o[1]), .a_rd_addr(aaddr_o[1]),
    .b_rd_en(brde_o[1]), .b_rd_addr(baddr_o[1]),
    .c_wr_en(cwe_o[1]), .c_wr_addr(caddr_o[1])
  );

  function automatic int f_xn(input int d);
    return (d == 0) ? X0 * N0 : X1 * N1;
  endfunction
  function automatic int f_ny(input int d);
    return (d == 0) ? N0 * Y0 : N1 * Y1;
  endfunction
  function automatic int f_xy(input int d);
    return (d == 0) ? X0 * Y0 : X1 * Y1;
  endfunction
  function automatic int f_lmax(input int d);
    return (f_xn(d) > f_ny(d)) ? f_xn(d) : f_ny(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is a timeline counted from its grant cycle (t=0)
  int          m_mode [2];   // 0 idle, 1 job active, 2 done cycle
  int          m_ptr  [2];
  int          m_w    [2];
  int          m_t    [2];
  int          m_nres [2];
  bit          m_seen [2];
  logic [7:0]  m_la [2], m_lb [2], m_lc [2];
  logic [1:0]  m_rq;
  bit          m_found;
  logic [1:0]  e_grant [2], e_done [2];
  logic        e_err [2], e_xin [2], e_yin [2], e_cwe [2];
  logic [7:0]  e_aaddr [2], e_baddr [2], e_caddr [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_mode[d] = 0; m_ptr[d] = 1; m_t[d] = 0; m_nres[d] = 0; m_seen[d] = 0;
        e_grant[d] = '0; e_done[d] = '0; e_err[d] = 0; e_xin[d] = 0; e_yin[d] = 0;
        e_cwe[d] = 0; e_aaddr[d] = '0; e_baddr[d] = '0; e_caddr[d] = '0;
      end else begin
        m_rq = (d == 0) ? req0 : req1;
        e_done[d] = '0; e_err[d] = 0; e_cwe[d] = 0;
        if (m_mode[d] == 0) begin
          m_found = 0;
          for (int k = 1; k <= 2; k++) begin
            if (!m_found && m_rq[(m_ptr[d] + k) % 2]) begin
              m_found = 1;
              m_w[d]  = (m_ptr[d] + k) % 2;
            end
          end
          if (m_found) begin
            m_ptr[d]  = m_w[d];
            m_la[d]   = a_base[m_w[d]*8 +: 8];
            m_lb[d]   = b_base[m_w[d]*8 +: 8];
            m_lc[d]   = c_base[m_w[d]*8 +: 8];
            m_mode[d] = 1; m_t[d] = 0; m_nres[d] = 0; m_seen[d] = 0;
            e_grant[d] = 2'(1 << m_w[d]);
          end
        end else if (m_mode[d] == 1) begin
          if (res_val && m_nres[d] < f_xy(d)) begin
            e_cwe[d]   = 1;
            e_caddr[d] = m_lc[d] + 8'(m_nres[d]);
            m_nres[d]++;
          end
          if (cal_done) m_seen[d] = 1;
          if (m_t[d] >= f_lmax(d) && m_seen[d] && m_nres[d] == f_xy(d)) begin
            m_mode[d] = 2;
            e_done[d] = e_grant[d];
          end else if (m_t[d] >= f_lmax(d) && (m_t[d] - f_lmax(d) + 1) == TO) begin
            e_err[d]   = 1;
            e_grant[d] = '0;
            m_mode[d]  = 0;
          end
          m_t[d]++;
        end else begin
          e_grant[d] = '0;
          m_mode[d]  = 0;
        end
        e_xin[d] = (m_mode[d] == 1) && (m_t[d] < f_xn(d));
        e_yin[d] = (m_mode[d] == 1) && (m_t[d] < f_ny(d));
        if (e_xin[d]) e_aaddr[d] = m_la[d] + 8'(m_t[d]);
        if (e_yin[d]) e_baddr[d] = m_lb[d] + 8'(m_t[d]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d grant", d), grant_o[d], e_grant[d]);
        check($sformatf("dut%0d done", d), done_o[d], e_done[d]);
        check($sformatf("dut%0d err", d), err_o[d], e_err[d]);
        check($sformatf("dut%0d Xin_val", d), xin_o[d], e_xin[d]);
        check($sformatf("dut%0d Yin_val", d), yin_o[d], e_yin[d]);
        check($sformatf("dut%0d a_rd_en", d), arde_o[d], e_xin[d]);
        check($sformatf("dut%0d b_rd_en", d), brde_o[d], e_yin[d]);
        check($sformatf("dut%0d c_wr_en", d), cwe_o[d], e_cwe[d]);
        if (e_xin[d]) check($sformatf("dut%0d a_rd_addr", d), aaddr_o[d], e_aaddr[d]);
        if (e_yin[d]) check($sformatf("dut%0d b_rd_addr", d), baddr_o[d], e_baddr[d]);
        if (e_cwe[d]) check($sformatf("dut%0d c_wr_addr", d), caddr_o[d], e_caddr[d]);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int d, output int n);
    n = 0;
    while (grant_o[d] == 2'b00 && n < 20) begin
      tick;
      n++;
    end
    check("grant wait", {31'd0, grant_o[d] != 2'b00}, 32'd1);
  endtask

  // One full job with results issued after LOAD, cal_done with the first result
  task automatic run_job(input int d, input logic [1:0] exp_g, output int n);
    wait_grant(d, n);
    check("job grant", grant_o[d], exp_g);
    repeat (f_lmax(d)) tick;
    for (int k = 0; k < f_xy(d); k++) begin
      res_val  = 1'b1;
      cal_done = (k == 0);
      tick;
    end
    res_val  = 1'b0;
    cal_done = 1'b0;
    check("job done", done_o[d], exp_g);
    tick;
    check("job grant clear", grant_o[d], 2'b00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nx, ny, nw, nd, cyc, dcyc;
    logic [7:0] la, lb, ea;
    rst_n = 1'b0; req0 = '0; req1 = '0; cal_done = 1'b0; res_val = 1'b0; chk_en = 1'b0;
    a_base = '0; b_base = '0; c_base = '0;
    repeat (3) tick;
    check("reset grant", grant_o[0], 2'b00);
    check("reset Xin_val", xin_o[0], 1'b0);
    check("reset a_rd_addr", aaddr_o[0], 8'h00);
    check("reset err", err_o[1], 1'b0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Single job with defaults
    a_base = {8'h60, 8'h10}; b_base = {8'h70, 8'h40}; c_base = {8'hA0, 8'h80};
    req0 = 2'b01;
    tick;
    check("t1 grant latency", grant_o[0], 2'b01);
    check("t1 first a addr", aaddr_o[0], 8'h10);
    check("t1 first b addr", baddr_o[0], 8'h40);
    req0 = 2'b00;
    nx = 0; ny = 0; la = '0; lb = '0;
    for (int i = 0; i < 12; i++) begin
      if (xin_o[0]) begin nx++; la = aaddr_o[0]; end
      if (yin_o[0]) begin ny++; lb = baddr_o[0]; end
      tick;
    end
    check("t1 Xin_val cycles", nx, 9);
    check("t1 Yin_val cycles", ny, 9);
    check("t1 last a addr", la, 8'h18);
    check("t1 last b addr", lb, 8'h48);
    for (int k = 0; k < 9; k++) begin
      res_val = 1'b1; cal_done = (k == 0);
      tick;
      check("t1 c_wr_en", cwe_o[0], 1'b1);
      check("t1 c_wr_addr", caddr_o[0], 8'h80 + 8'(k));
    end
    check("t1 done", done_o[0], 2'b01);
    res_val = 1'b0; cal_done = 1'b0;
    tick;
    check("t1 done width", done_o[0], 2'b00);
    check("t1 grant after done", grant_o[0], 2'b00);

    // Address wrap, 10th result ignored, cal_done arriving last
    tick;
    a_base = {8'h60, 8'hFE};
    req0 = 2'b01;
    tick;
    req0 = 2'b00;
    for (int i = 0; i < 9; i++) begin
      ea = 8'hFE + 8'(i);
      check("t2 wrapped a addr", aaddr_o[0], ea);
      tick;
    end
    for (int k = 0; k < 9; k++) begin
      res_val = 1'b1;
      tick;
    end
    check("t2 no done without cal_done", done_o[0], 2'b00);
    tick;
    check("t2 tenth res_val no write", cwe_o[0], 1'b0);
    res_val = 1'b0; cal_done = 1'b1;
    tick;
    check("t2 done after late cal_done", done_o[0], 2'b01);
    cal_done = 1'b0;
    nd = 0;
    for (int j = 0; j < 4; j++) begin
      tick;
      if (done_o[0] != 2'b00) nd++;
    end
    check("t2 no extra done", nd, 0);

    // cal_done coincident with the 9th result
    req0 = 2'b01;
    wait_grant(0, n);
    req0 = 2'b00;
    repeat (9) tick;
    for (int k = 0; k < 9; k++) begin
      res_val = 1'b1; cal_done = (k == 8);
      tick;
    end
    res_val = 1'b0; cal_done = 1'b0;
    nd = 0;
    for (int j = 0; j < 6; j++) begin
      if (done_o[0] == 2'b01) nd++;
      tick;
    end
    check("t3 single done pulse", nd, 1);

    // Round robin from reset with both requesters held
    @(posedge clk); #2 rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    req0 = 2'b11;
    run_job(0, 2'b01, n); check("t4 rr gap 1", n, 1);
    run_job(0, 2'b10, n); check("t4 rr gap 2", n, 1);
    run_job(0, 2'b01, n); check("t4 rr gap 3", n, 1);
    req0 = 2'b10;
    run_job(0, 2'b10, n); check("t4 req10 gap", n, 1);
    req0 = 2'b00;

    // Watchdog abort
    req0 = 2'b01;
    wait_grant(0, n);
    req0 = 2'b00;
    cyc = 0; nd = 0;
    while (!err_o[0] && cyc < 400) begin
      if (done_o[0] != 2'b00) nd++;
      tick;
      cyc++;
    end
    check("t5 err cycle after grant", cyc, 9 + TO);
    check("t5 no done on abort", nd, 0);
    check("t5 grant cleared on err", grant_o[0], 2'b00);
    req0 = 2'b01;
    tick;
    check("t5 next req served", grant_o[0], 2'b01);
    run_job(0, 2'b01, n);
    req0 = 2'b00;

    // Reset in the 4th LOAD cycle
    a_base = {8'h60, 8'h10};
    req0 = 2'b01;
    wait_grant(0, n);
    repeat (3) tick;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t6 reset grant", grant_o[0], 2'b00);
    check("t6 reset Xin_val", xin_o[0], 1'b0);
    check("t6 reset a_rd_en", arde_o[0], 1'b0);
    check("t6 reset a_rd_addr", aaddr_o[0], 8'h00);
    tick; tick;
    rst_n = 1'b1;
    wait_grant(0, n);
    check("t6 restart offset 0", aaddr_o[0], 8'h10);
    run_job(0, 2'b01, n);
    req0 = 2'b00;

    // Asymmetric geometry on instance 1
    a_base = {8'h00, 8'h20}; b_base = {8'h00, 8'h30}; c_base = {8'h00, 8'h50};
    req1 = 2'b01;
    wait_grant(1, n);
    req1 = 2'b00;
    nx = 0; ny = 0; nw = 0; dcyc = -1;
    for (cyc = 0; cyc < 21; cyc++) begin
      if (xin_o[1]) nx++;
      if (yin_o[1]) ny++;
      if (cwe_o[1]) nw++;
      if (done_o[1] != 2'b00 && dcyc < 0) dcyc = cyc;
      res_val  = (cyc < 6);
      cal_done = (cyc == 0);
      tick;
    end
    res_val = 1'b0; cal_done = 1'b0;
    check("t7 Xin_val cycles", nx, 8);
    check("t7 Yin_val cycles", ny, 12);
    check("t7 result writes", nw, 6);
    check("t7 done cycle", dcyc, 13);

    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
